// File: rtl/fxp_pkg.sv
// fxp_pkg: shared state type and sizing helpers for the fixed-point math blocks
package fxp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} divState;

    function automatic int iterCount(input int wholeWidth, input int fractionWidth);
        return wholeWidth + 2 * fractionWidth;
    endfunction

    function automatic logic [63:0] satValue(input int width);
        return (width >= 64) ? '1 : (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/fxp_div_step.sv
// fxp_div_step: one combinational restoring-division iteration
module fxp_div_step #(
    parameter int width = 32
) (
    input  logic [width:0]   partialIn,
    input  logic             dividendBit,
    input  logic [width-1:0] divisor,
    output logic [width:0]   partialOut,
    output logic             quotientBit
);

    logic [width+1:0] shifted;
    logic [width+1:0] extDivisor;

    assign shifted     = {partialIn, dividendBit};
    assign extDivisor  = {2'b00, divisor};
    assign quotientBit = shifted >= extDivisor;
    // the restored remainder is always below the divisor, so the top bit is always zero
    assign partialOut  = (width+1)'(quotientBit ? shifted - extDivisor : shifted);

endmodule

// File: rtl/fxp_div.sv
// fxp_div: sequential restoring Q-format divider; FXP_DIV_REMAINDER_EN adds the remainder port
module fxp_div
    import fxp_pkg::*;
#(
    parameter int wholeWidth    = 16,
    parameter int fractionWidth = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                calculate_en,
    input  logic [wholeWidth+fractionWidth-1:0] valueOne,
    input  logic [wholeWidth+fractionWidth-1:0] valueTwo,
    output logic [wholeWidth+fractionWidth-1:0] quotient,
`ifdef FXP_DIV_REMAINDER_EN
    output logic [wholeWidth+fractionWidth:0]   remainder,
`endif
    output logic                                busy,
    output logic                                done,
    output logic                                divByZero,
    output logic                                overflow
);

    localparam int TOTAL = wholeWidth + fractionWidth;
    localparam int ITER  = iterCount(wholeWidth, fractionWidth);
    localparam int CW    = $clog2(ITER);
    localparam logic [TOTAL-1:0] SAT = TOTAL'(satValue(TOTAL));

    divState           state, nextState;
    logic [TOTAL-1:0]  divisorReg;
    logic [ITER-1:0]   dividendReg;
    logic [TOTAL:0]    partialReg, nextPartial;
    logic [ITER-2:0]   quotReg;
    logic [ITER-1:0]   fullQuot;
    logic              quotBit;
    logic [CW-1:0]     count;
    logic              accept, lastStep, fullOverflow;

    assign accept       = state == IDLE && calculate_en;
    assign lastStep     = state == RUN && count == '0;
    // the oldest quotient bit is shifted out exactly when the last one arrives, so only ITER-1 are stored
    assign fullQuot     = {quotReg, quotBit};
    assign fullOverflow = |fullQuot[ITER-1:TOTAL];

    fxp_div_step #(.width(TOTAL)) step (
        .partialIn  (partialReg),
        .dividendBit(dividendReg[ITER-1]),
        .divisor    (divisorReg),
        .partialOut (nextPartial),
        .quotientBit(quotBit)
    );

    // state register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : nextState;
    end

    // next-state decode
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = calculate_en ? ((valueTwo == '0) ? DONE : RUN) : IDLE;
            RUN:     nextState = (count == '0) ? DONE : RUN;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // datapath, iteration counter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            divisorReg  <= '0;
            dividendReg <= '0;
            partialReg  <= '0;
            quotReg     <= '0;
            count       <= '0;
            quotient    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            divByZero   <= 1'b0;
            overflow    <= 1'b0;
`ifdef FXP_DIV_REMAINDER_EN
            remainder   <= '0;
`endif
        end else begin
            busy <= nextState == RUN;
            done <= nextState == DONE;
            if (accept) begin
                divisorReg  <= valueTwo;
                dividendReg <= {valueOne, {fractionWidth{1'b0}}};
                partialReg  <= '0;
                quotReg     <= '0;
                count       <= CW'(ITER - 1);
                if (valueTwo == '0) begin
                    quotient  <= SAT;
                    divByZero <= 1'b1;
                    overflow  <= 1'b0;
`ifdef FXP_DIV_REMAINDER_EN
                    remainder <= '0;
`endif
                end
            end else if (state == RUN) begin
                dividendReg <= {dividendReg[ITER-2:0], 1'b0};
                partialReg  <= nextPartial;
                quotReg     <= fullQuot[ITER-2:0];
                count       <= count - 1'b1;
                if (lastStep) begin
                    quotient  <= fullOverflow ? SAT : fullQuot[TOTAL-1:0];
                    overflow  <= fullOverflow;
                    divByZero <= 1'b0;
`ifdef FXP_DIV_REMAINDER_EN
                    remainder <= nextPartial;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_fxp_div.sv
// tb_fxp_div: scoreboard bench for fxp_div at default widths
module tb_fxp_div;

    localparam int ITER = 48;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        calculate_en = 1'b0;
    logic [31:0] valueOne = '0;
    logic [31:0] valueTwo = '0;
    logic [31:0] quotient;
    logic        busy, done, divByZero, overflow;
`ifdef FXP_DIV_REMAINDER_EN
    logic [32:0] remainder;
`endif

    int assertions = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] q;
        logic        dz;
        logic        ov;
        logic [32:0] rem;
    } expT;

    expT sb[$];

    fxp_div dut (
        .clock       (clock),
        .reset       (reset),
        .calculate_en(calculate_en),
        .valueOne    (valueOne),
        .valueTwo    (valueTwo),
        .quotient    (quotient),
`ifdef FXP_DIV_REMAINDER_EN
        .remainder   (remainder),
`endif
        .busy        (busy),
        .done        (done),
        .divByZero   (divByZero),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    function automatic expT model(input logic [31:0] a, input logic [31:0] b);
        expT e;
        logic [63:0] num, qq;
        num = {16'h0, a, 16'h0};
        if (b == 0) begin
            e.q = '1; e.dz = 1'b1; e.ov = 1'b0; e.rem = '0;
        end else begin
            qq = num / {32'h0, b};
            e.dz = 1'b0;
            e.ov = qq[63:32] != 0;
            e.q = e.ov ? 32'hFFFFFFFF : qq[31:0];
            e.rem = 33'(num % {32'h0, b});
        end
        return e;
    endfunction

    // called #1 after an edge with the DUT idle; returns #1 after the accepting edge
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        valueOne = a;
        valueTwo = b;
        calculate_en = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clock); #1;
        calculate_en = 1'b0;
        valueOne = $urandom;
        valueTwo = $urandom;
    endtask

    task automatic awaitDone(output int lat, output int busyN, output bit both);
        lat = 0; busyN = 0; both = 0;
        while (1) begin
            if (busy) busyN++;
            if (busy && done) both = 1;
            if (done || lat >= 200) break;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic nextEdge();
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        assertions++; if ({busy, done, divByZero, overflow} !== 4'b0) begin failures++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, divByZero, overflow}); end
        assertions++; if (quotient !== 32'h0) begin failures++; $display("FAIL reset_quotient: got %h expected 00000000", quotient); end
`ifdef FXP_DIV_REMAINDER_EN
        assertions++; if (remainder !== 33'h0) begin failures++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
`endif
        reset = 1'b0;
        repeat (3) nextEdge();
        assertions++; if (busy || done) begin failures++; $display("FAIL idle_quiet: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_divide();
        logic [31:0] ops[8][2] = '{
            '{32'h00030000, 32'h00020000}, '{32'h00010000, 32'h00030000},
            '{32'h7FFF0000, 32'h00000001}, '{32'hFFFFFFFF, 32'hFFFFFFFF},
            '{32'h00000000, 32'h00000005}, '{32'hFFFF0000, 32'h00010000},
            '{32'hFFFFFFFF, 32'h0000FFFF}, '{32'h00008000, 32'h00010000}};
        int lat, busyN;
        bit both;
        expT e;
        for (int i = 0; i < 10; i++) begin
            if (i < 8) launch(ops[i][0], ops[i][1]);
            else launch($urandom, $urandom_range(1, 32'h0003FFFF));
            awaitDone(lat, busyN, both);
            e = sb.pop_front();
            assertions++; if (lat != ITER) begin failures++; $display("FAIL div%0d_latency: got %0d expected %0d", i, lat, ITER); end
            assertions++; if (busyN != ITER || both) begin failures++; $display("FAIL div%0d_busy: got %0d cycles overlap=%0d expected %0d cycles overlap=0", i, busyN, both, ITER); end
            assertions++; if (quotient !== e.q) begin failures++; $display("FAIL div%0d_quotient: got %h expected %h", i, quotient, e.q); end
            assertions++; if ({divByZero, overflow} !== {e.dz, e.ov}) begin failures++; $display("FAIL div%0d_flags: got dz=%b ov=%b expected dz=%b ov=%b", i, divByZero, overflow, e.dz, e.ov); end
`ifdef FXP_DIV_REMAINDER_EN
            assertions++; if (remainder !== e.rem) begin failures++; $display("FAIL div%0d_remainder: got %h expected %h", i, remainder, e.rem); end
`endif
            nextEdge();
            assertions++; if (done || quotient !== e.q) begin failures++; $display("FAIL div%0d_hold: got done=%b q=%h expected done=0 q=%h", i, done, quotient, e.q); end
        end
    endtask

    task automatic test_div_zero();
        int lat, busyN;
        bit both;
        expT e;
        launch(32'h12345678, 32'h00000000);
        awaitDone(lat, busyN, both);
        e = sb.pop_front();
        assertions++; if (lat != 0 || busyN != 0) begin failures++; $display("FAIL dz_timing: got latency %0d busy %0d expected 0 0", lat, busyN); end
        assertions++; if (quotient !== e.q) begin failures++; $display("FAIL dz_quotient: got %h expected %h", quotient, e.q); end
        assertions++; if ({divByZero, overflow} !== 2'b10) begin failures++; $display("FAIL dz_flags: got dz=%b ov=%b expected dz=1 ov=0", divByZero, overflow); end
`ifdef FXP_DIV_REMAINDER_EN
        assertions++; if (remainder !== 33'h0) begin failures++; $display("FAIL dz_remainder: got %h expected 0", remainder); end
`endif
        nextEdge();
    endtask

    task automatic test_ignore_during_run();
        int lat, busyN, extra;
        bit both;
        expT e;
        launch(32'h000A0000, 32'h00040000);
        repeat (9) nextEdge();
        valueOne = 32'h00010000;
        valueTwo = 32'h00000000;
        calculate_en = 1'b1;
        nextEdge();
        calculate_en = 1'b0;
        awaitDone(lat, busyN, both);
        e = sb.pop_front();
        assertions++; if (lat != ITER - 10) begin failures++; $display("FAIL ignore_latency: got %0d expected %0d", lat, ITER - 10); end
        assertions++; if (quotient !== e.q || divByZero !== 1'b0) begin failures++; $display("FAIL ignore_quotient: got %h dz=%b expected %h dz=0", quotient, divByZero, e.q); end
        extra = 0;
        repeat (60) begin
            nextEdge();
            if (done || busy) extra++;
        end
        assertions++; if (extra != 0) begin failures++; $display("FAIL ignore_not_queued: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_mid_reset();
        int lat, busyN;
        bit both;
        expT e;
        launch(32'h00050000, 32'h00030000);
        repeat (19) nextEdge();
        reset = 1'b1;
        nextEdge();
        assertions++; if ({busy, done, divByZero, overflow} !== 4'b0 || quotient !== 32'h0) begin failures++; $display("FAIL midreset_outputs: got b=%b d=%b dz=%b ov=%b q=%h expected all 0", busy, done, divByZero, overflow, quotient); end
`ifdef FXP_DIV_REMAINDER_EN
        assertions++; if (remainder !== 33'h0) begin failures++; $display("FAIL midreset_remainder: got %h expected 0", remainder); end
`endif
        reset = 1'b0;
        void'(sb.pop_back());
        nextEdge();
        launch(32'h00070000, 32'h00020000);
        awaitDone(lat, busyN, both);
        e = sb.pop_front();
        assertions++; if (lat != ITER || quotient !== e.q) begin failures++; $display("FAIL midreset_fresh: got latency %0d q=%h expected %0d q=%h", lat, quotient, ITER, e.q); end
        nextEdge();
    endtask

    task automatic test_back_to_back();
        int lat, busyN;
        bit both;
        expT e;
        valueOne = 32'h00090000;
        valueTwo = 32'h00030000;
        calculate_en = 1'b1;
        sb.push_back(model(valueOne, valueTwo));
        nextEdge();
        awaitDone(lat, busyN, both);
        e = sb.pop_front();
        assertions++; if (lat != ITER || quotient !== e.q) begin failures++; $display("FAIL b2b_first: got latency %0d q=%h expected %0d q=%h", lat, quotient, ITER, e.q); end
        valueOne = 32'h00020000;
        valueTwo = 32'h00080000;
        sb.push_back(model(valueOne, valueTwo));
        nextEdge();
        assertions++; if (busy || done) begin failures++; $display("FAIL b2b_idle_gap: got busy=%b done=%b expected 0 0", busy, done); end
        nextEdge();
        calculate_en = 1'b0;
        awaitDone(lat, busyN, both);
        e = sb.pop_front();
        assertions++; if (lat != ITER || quotient !== e.q) begin failures++; $display("FAIL b2b_second: got latency %0d q=%h expected %0d q=%h", lat, quotient, ITER, e.q); end
        nextEdge();
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_zero();
        test_ignore_during_run();
        test_mid_reset();
        test_back_to_back();
        assertions++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/fxp_div.md
# fxp_div

Sequential unsigned fixed-point divider for the Q(wholeWidth.fractionWidth) format used by the fixed-point multiplier in the math library. It computes valueOne / valueTwo by restoring division, one quotient bit per clock. A start/done handshake brackets each operation. It flags divide-by-zero and overflow, saturating the result in both cases.

## Interface
- wholeWidth, 16: integer bits per operand and result
- fractionWidth, 16: fraction bits per operand and result
- clock  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high; returns block to IDLE
- calculate_en  input  1  start request; accepted only in IDLE
- valueOne  input  wholeWidth+fractionWidth  dividend, unsigned Q format
- valueTwo  input  wholeWidth+fractionWidth  divisor, unsigned Q format
- quotient  output  wholeWidth+fractionWidth  result, unsigned Q format
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags valid
- divByZero  output  1  last operation had valueTwo == 0
- overflow  output  1  last quotient exceeded the representable range
- remainder  output  wholeWidth+fractionWidth+1  final partial remainder (only with FXP_DIV_REMAINDER_EN)

## Operation
- Terms: TOTAL = wholeWidth+fractionWidth; ITER = TOTAL+fractionWidth.
- Computed value: floor((valueOne << fractionWidth) / valueTwo), with ITER quotient bits, truncated toward zero.
- FSM states and transitions:
  - IDLE -> RUN when calculate_en=1 and valueTwo != 0.
  - IDLE -> DONE when calculate_en=1 and valueTwo == 0.
  - RUN -> DONE after ITER iterations.
  - DONE -> IDLE unconditionally.
- On accept:
  - Latch valueTwo.
  - Load the dividend shift register (ITER bits) with {valueOne, fractionWidth zeros}.
  - Clear the partial remainder (TOTAL+1 bits) and the quotient register (ITER bits).
  - Load the iteration counter with ITER-1.
- Each RUN cycle:
  - R' = {R, next dividend MSB}.
  - If R' >= divisor: R = R' - divisor and shift in quotient bit 1; else R = R' and shift in 0.
- Overflow: any of quotient register bits [ITER-1:TOTAL] set. Then quotient = all ones and overflow = 1; otherwise quotient = low TOTAL bits.
- Divide-by-zero: quotient = all ones, divByZero = 1, overflow = 0; no iterations are run.
- quotient and both flags are updated only on entry to DONE. They hold until the next DONE.
- Inputs are sampled only on the accepting edge and may change afterwards.
- calculate_en while in RUN or DONE is ignored, not queued.
- Reset, including mid-operation: state IDLE; quotient, remainder, counter, busy, done, divByZero and overflow all 0.

## Timing
- The accepting edge is edge k.
- Normal operation: busy is high for cycles k+1 .. k+ITER. done is high during cycle k+ITER+1 only. Defaults: done is high 49 cycles after accept.
- Divide-by-zero: done is high in cycle k+1 and busy never asserts.
- busy and done are never high together.
- The earliest next accept is the edge that ends the DONE cycle (the first IDLE cycle). Throughput is one operation per ITER+2 cycles.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- FXP_DIV_REMAINDER_EN defined:
  - The remainder port exists.
  - It is loaded on DONE with the final partial remainder R; it is 0 for divide-by-zero and 0 on reset.
- FXP_DIV_REMAINDER_EN undefined:
  - The port and its register are absent.
  - quotient, flags and timing are identical.

## Structure
- Shared package fxp_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - a function computing ITER from the two width parameters;
  - the saturation-value constant helper.
- Sub-module fxp_div_step is the combinational single iteration: inputs R, dividend bit and divisor; outputs next R and quotient bit. It is instantiated once inside fxp_div.

## Test plan
- 0x00030000 / 0x00020000 (3.0/2.0) -> done at k+49, quotient 0x00018000, both flags 0.
- 0x00010000 / 0x00030000 (1/3) -> quotient 0x00005555, remainder 0x10000 with FXP_DIV_REMAINDER_EN.
- 0x7FFF0000 / 0x00000001 -> quotient 0xFFFFFFFF, overflow 1, divByZero 0.
- 0x12345678 / 0x00000000 -> done at k+1, quotient 0xFFFFFFFF, divByZero 1, busy never high.
- Pulse calculate_en at k+10 with different operands during RUN -> ignored; result matches the first operation.
- Assert reset at k+20 -> next cycle busy 0, done 0, all outputs 0; a fresh operation then completes correctly.
